// File: rtl/instr_fetch_ifid_pkg.sv
// Shared constants for the fetch stage / IF/ID register and its byte loader.
package instr_fetch_ifid_pkg;
  localparam int          LOAD_BYTE_W    = 8;
  localparam int          BYTES_PER_WORD = 4;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
  localparam logic [5:0]  HALT_OPCODE    = 6'b111111;
endpackage

// File: rtl/instr_fetch_ifid_loader.sv
// Byte-serial instruction memory loader: assembles big-endian words while the
// pipeline is halted and emits one write per completed word.
module imem_byte_loader
  import instr_fetch_ifid_pkg::*;
#(
  parameter int NB_WIDTH  = 32,
  parameter int MEM_DEPTH = 256,
  localparam int NB_ADDR  = $clog2(MEM_DEPTH)
) (
  input  logic                   clk,
  input  logic                   i_rst,
  input  logic                   i_halt,
  input  logic                   i_load_valid,
  input  logic [LOAD_BYTE_W-1:0] i_load_byte,
  input  logic                   i_load_clear,
  output logic                   o_load_ready,
  output logic [NB_ADDR:0]       o_load_words,
  output logic                   o_we,
  output logic [NB_ADDR-1:0]     o_waddr,
  output logic [NB_WIDTH-1:0]    o_wdata
);
  localparam int ASM_W = NB_WIDTH - LOAD_BYTE_W;

  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [ASM_W-1:0] asm_q, asm_d;
  logic [NB_ADDR:0] wptr_q, wptr_d;
  logic             accept;
  logic             last_byte;

  // The pointer MSB is set exactly when all MEM_DEPTH words have been written.
  assign o_load_ready = i_halt && !wptr_q[NB_ADDR];
  assign accept       = i_load_valid && o_load_ready && !i_load_clear;
  assign last_byte    = (byte_cnt_q == 2'(BYTES_PER_WORD - 1));

  assign o_we         = accept && last_byte;
  assign o_waddr      = wptr_q[NB_ADDR-1:0];
  assign o_wdata      = {asm_q, i_load_byte};
  assign o_load_words = wptr_q;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    wptr_d     = wptr_q;
    if (i_load_clear) begin
      byte_cnt_d = 2'd0;
      wptr_d     = '0;
    end else if (accept) begin
      if (last_byte) begin
        byte_cnt_d = 2'd0;
        wptr_d     = wptr_q + {{NB_ADDR{1'b0}}, 1'b1};
      end else begin
        byte_cnt_d = byte_cnt_q + 2'd1;
        asm_d      = {asm_q[ASM_W-LOAD_BYTE_W-1:0], i_load_byte};
      end
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      byte_cnt_q <= 2'd0;
      asm_q      <= '0;
      wptr_q     <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      wptr_q     <= wptr_d;
    end
  end
endmodule

// File: rtl/instr_fetch_ifid.sv
// Fetch stage with instruction memory, byte loader and IF/ID register.
// Define IMEM_BOUNDS_CHECK_EN to reject out-of-range/misaligned fetches (o_addr_err).
module instr_fetch_ifid
  import instr_fetch_ifid_pkg::*;
#(
  parameter int NB_WIDTH  = 32,
  parameter int MEM_DEPTH = 256,
  localparam int NB_ADDR  = $clog2(MEM_DEPTH)
) (
  input  logic                   clk,
  input  logic                   i_rst,
  input  logic [NB_WIDTH-1:0]    i_pcounter,
  input  logic [NB_WIDTH-1:0]    i_pcounter4,
  input  logic                   i_stall,
  input  logic                   i_flush,
  input  logic                   i_halt,
  input  logic                   i_load_valid,
  input  logic [LOAD_BYTE_W-1:0] i_load_byte,
  input  logic                   i_load_clear,
  output logic                   o_load_ready,
  output logic [NB_ADDR:0]       o_load_words,
  output logic [NB_WIDTH-1:0]    o_instr,
  output logic [NB_WIDTH-1:0]    o_pcounter4,
  output logic                   o_valid
`ifdef IMEM_BOUNDS_CHECK_EN
  ,
  output logic                   o_addr_err
`endif
);
  logic [NB_WIDTH-1:0] mem [MEM_DEPTH];
  logic                we;
  logic [NB_ADDR-1:0]  waddr;
  logic [NB_WIDTH-1:0] wdata;
  logic [NB_ADDR-1:0]  rd_idx;
  logic [NB_WIDTH-1:0] rd_word;
  logic [NB_WIDTH-1:0] instr_q;
  logic [NB_WIDTH-1:0] pc4_q;
  logic                valid_q;

  imem_byte_loader #(
    .NB_WIDTH (NB_WIDTH),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_loader (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_halt      (i_halt),
    .i_load_valid(i_load_valid),
    .i_load_byte (i_load_byte),
    .i_load_clear(i_load_clear),
    .o_load_ready(o_load_ready),
    .o_load_words(o_load_words),
    .o_we        (we),
    .o_waddr     (waddr),
    .o_wdata     (wdata)
  );

  // Memory contents survive reset so a loaded program outlives a core reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rd_idx  = i_pcounter[NB_ADDR+1:2];
  assign rd_word = mem[rd_idx];

`ifdef IMEM_BOUNDS_CHECK_EN
  logic addr_bad;
  logic addr_err_q;
  assign addr_bad   = (i_pcounter[NB_WIDTH-1:NB_ADDR+2] != '0) || (i_pcounter[1:0] != 2'b00);
  assign o_addr_err = addr_err_q;
`else
  logic unused_pc_bits;
  assign unused_pc_bits = ^{i_pcounter[NB_WIDTH-1:NB_ADDR+2], i_pcounter[1:0]};
`endif

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      instr_q    <= NB_WIDTH'(NOP_INSTR);
      pc4_q      <= '0;
      valid_q    <= 1'b0;
`ifdef IMEM_BOUNDS_CHECK_EN
      addr_err_q <= 1'b0;
`endif
    end else if (i_halt) begin
      instr_q <= instr_q;
    end else if (i_flush) begin
      instr_q <= NB_WIDTH'(NOP_INSTR);
      pc4_q   <= i_pcounter4;
      valid_q <= 1'b0;
    end else if (!i_stall) begin
      pc4_q <= i_pcounter4;
`ifdef IMEM_BOUNDS_CHECK_EN
      if (addr_bad) begin
        instr_q    <= NB_WIDTH'(NOP_INSTR);
        valid_q    <= 1'b0;
        addr_err_q <= 1'b1;
      end else begin
        instr_q <= rd_word;
        valid_q <= 1'b1;
      end
`else
      instr_q <= rd_word;
      valid_q <= 1'b1;
`endif
    end
  end

  assign o_instr     = instr_q;
  assign o_pcounter4 = pc4_q;
  assign o_valid     = valid_q;
endmodule

// File: tb/tb_instr_fetch_ifid.sv
// Directed bench for instr_fetch_ifid (MEM_DEPTH=4) with a cycle-stamped scoreboard.
module tb_instr_fetch_ifid;
  localparam int DEPTH = 4;
  localparam int NBA   = 2;
  localparam int W     = 94;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   pc, pc4;
  logic          stall, flush, halt, lvalid, lclear;
  logic [7:0]    lbyte;
  logic          load_ready;
  logic [NBA:0]  load_words;
  logic [31:0]   instr, pc4_o;
  logic          valid;
  logic          err_act;

  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;
  logic          exp_err_bit = 1'b0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  e;
  logic [68:0]   act;

  always #5 clk = ~clk;

  instr_fetch_ifid #(
    .NB_WIDTH (32),
    .MEM_DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .i_rst       (rst),
    .i_pcounter  (pc),
    .i_pcounter4 (pc4),
    .i_stall     (stall),
    .i_flush     (flush),
    .i_halt      (halt),
    .i_load_valid(lvalid),
    .i_load_byte (lbyte),
    .i_load_clear(lclear),
    .o_load_ready(load_ready),
    .o_load_words(load_words),
    .o_instr     (instr),
    .o_pcounter4 (pc4_o),
    .o_valid     (valid)
`ifdef IMEM_BOUNDS_CHECK_EN
    ,
    .o_addr_err  (err_act)
`endif
  );
`ifndef IMEM_BOUNDS_CHECK_EN
  assign err_act = 1'b0;
`endif

  task automatic drive(input logic [31:0] p, input logic [31:0] p4, input logic st,
                       input logic fl, input logic ht, input logic lv,
                       input logic [7:0] lb, input logic lc);
    @(negedge clk);
    pc = p; pc4 = p4; stall = st; flush = fl; halt = ht;
    lvalid = lv; lbyte = lb; lclear = lc;
  endtask

  task automatic ld(input logic [7:0] b);
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, b, 1'b0);
  endtask

  task automatic run(input logic [31:0] p, input logic [31:0] p4);
    drive(p, p4, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // Expected state right after the next rising edge.
  task automatic expect_next(input logic [7:0] tag, input logic [31:0] ins, input logic [31:0] p4,
                             input logic v, input logic [NBA:0] w, input logic rdy);
    exp_q.push_back({16'(cyc + 1), tag, exp_err_bit, rdy, w, v, p4, ins});
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    while (exp_q.size() > 0 && int'(exp_q[0][W-1 -: 16]) <= cyc) begin
      e   = exp_q.pop_front();
      act = {load_ready, load_words, valid, pc4_o, instr};
      checks++;
      if (int'(e[W-1 -: 16]) != cyc) begin
        errors++;
        $display("FAIL check %0d late: due cycle %0d, seen cycle %0d", e[77:70], e[W-1 -: 16], cyc);
      end else if (act !== e[68:0]) begin
        errors++;
        $display("FAIL check %0d: got rdy=%b words=%0d valid=%b pc4=%h instr=%h, expected rdy=%b words=%0d valid=%b pc4=%h instr=%h",
                 e[77:70], act[68], act[67:65], act[64], act[63:32], act[31:0],
                 e[68], e[67:65], e[64], e[63:32], e[31:0]);
      end
`ifdef IMEM_BOUNDS_CHECK_EN
      checks++;
      if (err_act !== e[69]) begin
        errors++;
        $display("FAIL check %0d addr_err: got %b, expected %b", e[77:70], err_act, e[69]);
      end
`endif
    end
  end

  initial begin
    rst = 1'b1; pc = '0; pc4 = '0; stall = 1'b0; flush = 1'b0; halt = 1'b1;
    lvalid = 1'b0; lbyte = '0; lclear = 1'b0;

    // Reset state
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    expect_next(1, 32'h0, 32'h0, 1'b0, 3'd0, 1'b1);
    @(negedge clk); rst = 1'b0;

    // Load two words while halted
    ld(8'h12); ld(8'h34); ld(8'h56); ld(8'h78);
    expect_next(2, 32'h0, 32'h0, 1'b0, 3'd1, 1'b1);
    ld(8'hAA); ld(8'hBB); ld(8'hCC); ld(8'hDD);
    expect_next(3, 32'h0, 32'h0, 1'b0, 3'd2, 1'b1);

    // Normal fetch, one cycle latency
    run(32'h0, 32'h4);  expect_next(4, 32'h12345678, 32'h4, 1'b1, 3'd2, 1'b0);
    run(32'h4, 32'h8);  expect_next(5, 32'hAABBCCDD, 32'h8, 1'b1, 3'd2, 1'b0);

    // Flush, then flush+stall
    drive(32'h0, 32'h4, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    expect_next(6, 32'h0, 32'h4, 1'b0, 3'd2, 1'b0);
    run(32'h4, 32'h8);  expect_next(7, 32'hAABBCCDD, 32'h8, 1'b1, 3'd2, 1'b0);
    drive(32'h0, 32'h4, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    expect_next(8, 32'h0, 32'h4, 1'b0, 3'd2, 1'b0);
    run(32'h0, 32'h4);  expect_next(9, 32'h12345678, 32'h4, 1'b1, 3'd2, 1'b0);

    // Two-cycle stall holds everything
    drive(32'h4, 32'h8, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    expect_next(10, 32'h12345678, 32'h4, 1'b1, 3'd2, 1'b0);
    drive(32'h4, 32'h8, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    expect_next(11, 32'h12345678, 32'h4, 1'b1, 3'd2, 1'b0);
    run(32'h4, 32'h8);  expect_next(12, 32'hAABBCCDD, 32'h8, 1'b1, 3'd2, 1'b0);

    // Halt holds, halt beats flush
    drive(32'h0, 32'h4, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    expect_next(13, 32'hAABBCCDD, 32'h8, 1'b1, 3'd2, 1'b1);
    drive(32'h0, 32'h4, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    expect_next(14, 32'hAABBCCDD, 32'h8, 1'b1, 3'd2, 1'b1);

    // Clear mid-word (clear wins over valid), then reload word 0
    ld(8'h11); ld(8'h22);
    drive(32'h0, 32'h4, 1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1);
    expect_next(15, 32'hAABBCCDD, 32'h8, 1'b1, 3'd0, 1'b1);
    ld(8'h44); ld(8'h55); ld(8'h66); ld(8'h77);
    expect_next(16, 32'hAABBCCDD, 32'h8, 1'b1, 3'd1, 1'b1);

    // Reset in the middle of a word
    ld(8'h88); ld(8'h99);
    @(negedge clk); rst = 1'b1; lvalid = 1'b0;
    expect_next(17, 32'h0, 32'h0, 1'b0, 3'd0, 1'b1);
    @(negedge clk); rst = 1'b0;

    // Fill all four words, 17th byte dropped
    ld(8'hA1); ld(8'hA2); ld(8'hA3); ld(8'hA4);
    ld(8'hB1); ld(8'hB2); ld(8'hB3); ld(8'hB4);
    ld(8'hC1); ld(8'hC2); ld(8'hC3); ld(8'hC4);
    ld(8'hD1); ld(8'hD2); ld(8'hD3); ld(8'hD4);
    expect_next(18, 32'h0, 32'h0, 1'b0, 3'd4, 1'b0);
    ld(8'hFF);
    expect_next(19, 32'h0, 32'h0, 1'b0, 3'd4, 1'b0);

    run(32'h0, 32'h4);   expect_next(20, 32'hA1A2A3A4, 32'h4, 1'b1, 3'd4, 1'b0);
    run(32'hC, 32'h10);  expect_next(21, 32'hD1D2D3D4, 32'h10, 1'b1, 3'd4, 1'b0);

    // PC beyond memory: wraps by default, rejected with bounds checking
    run(32'h10, 32'h14);
`ifdef IMEM_BOUNDS_CHECK_EN
    exp_err_bit = 1'b1;
    expect_next(22, 32'h0, 32'h14, 1'b0, 3'd4, 1'b0);
`else
    expect_next(22, 32'hA1A2A3A4, 32'h14, 1'b1, 3'd4, 1'b0);
`endif
    run(32'h8, 32'hC);   expect_next(23, 32'hC1C2C3C4, 32'hC, 1'b1, 3'd4, 1'b0);

    // Clear while halted does not erase memory; partial word survives un-halt
    drive(32'h0, 32'h4, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    expect_next(24, 32'hC1C2C3C4, 32'hC, 1'b1, 3'd0, 1'b1);
    ld(8'hE1); ld(8'hE2);
    drive(32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 1'b1, 8'h99, 1'b0);
    expect_next(25, 32'hA1A2A3A4, 32'h4, 1'b1, 3'd0, 1'b0);
    ld(8'hE3); ld(8'hE4);
    expect_next(26, 32'hA1A2A3A4, 32'h4, 1'b1, 3'd1, 1'b1);
    run(32'h0, 32'h4);   expect_next(27, 32'hE1E2E3E4, 32'h4, 1'b1, 3'd1, 1'b0);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      $display("FAIL leftover: %0d expected entries never checked, required 0", exp_q.size());
      errors += exp_q.size();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
